// File: rtl/fb_scanout_pkg.sv
// Shared constants and state encoding for the frame-buffer scanout stage.
package fb_scanout_pkg;

    localparam int FB_AW      = 20;
    localparam int PIX_W      = 24;
    localparam int DEF_WIDTH  = 128;
    localparam int DEF_HEIGHT = 128;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        FETCH = S_FETCH,
        DRAIN = S_DRAIN
    } state_t;

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_fifo.sv
// Synchronous FIFO with first-word-fall-through: dout shows the head entry
// whenever the FIFO is not empty.
module fb_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
    underflow_chk: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/fb_scanout.sv
// Reads a finished frame from image memory and streams it out as raster
// pixels with SOF/SOL/EOL markers, prefetching into a small FIFO.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [FB_AW-1:0] fb_base,
    output logic [FB_AW-1:0] FB_A,
    output logic             FB_REN,
    input  logic [PIX_W-1:0] FB_Q,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_sof,
    output logic             pix_sol,
    output logic             pix_eol,
    output logic             busy
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int XW   = cnt_bits(WIDTH);
    localparam int YW   = cnt_bits(HEIGHT);
    localparam int PW   = cnt_bits(NPIX);
    localparam int CW   = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
    localparam logic [CW:0]   CREDIT = (CW + 1)'(FIFO_DEPTH);

    state_t           state;
    logic [FB_AW-1:0] rd_addr;
    logic [PW-1:0]    rd_cnt;
    logic             inflight;
    logic [XW-1:0]    out_x;
    logic [YW-1:0]    out_y;

    logic [CW:0]      fifo_count;
    logic [CW:0]      credit_used;
    logic             fifo_empty;
    logic             fifo_full;
    logic [PIX_W-1:0] fifo_dout;
    logic             pop;
    logic             last_pix;

    fb_fifo #(
        .DW    (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   (FB_Q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // A read in flight already owns a FIFO slot, so it counts against credit.
    assign credit_used = fifo_count + {{CW{1'b0}}, inflight};
    assign FB_REN      = (state == FETCH) && (credit_used < CREDIT);
    assign FB_A        = rd_addr;

    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? fifo_dout : '0;
    assign pop       = pix_valid && pix_ready;
    assign last_pix  = (out_x == X_LAST) && (out_y == Y_LAST);

    assign pix_sof = pix_valid && (out_x == '0) && (out_y == '0);
    assign pix_sol = pix_valid && (out_x == '0);
    assign pix_eol = pix_valid && (out_x == X_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            rd_cnt   <= '0;
            inflight <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
            busy     <= 1'b0;
        end else begin
            inflight <= FB_REN;

            if (pop) begin
                if (out_x == X_LAST) begin
                    out_x <= '0;
                    out_y <= out_y + YW'(1);
                end else begin
                    out_x <= out_x + XW'(1);
                end
            end

            // The IDLE clear is placed after the pop update so a fresh start always wins.
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr <= fb_base;
                        rd_cnt  <= '0;
                        out_x   <= '0;
                        out_y   <= '0;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (FB_REN) begin
                        rd_addr <= rd_addr + FB_AW'(1);
                        rd_cnt  <= rd_cnt + PW'(1);
                        if (rd_cnt == P_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_pix) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    capture_chk: assert property (@(posedge clk) disable iff (reset) !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: small 4x2 and 4x1 frames plus a full
// 128x128 frame with random back-pressure, against a memory where mem[a]=a.
module tb_fb_scanout;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 4x2 instance
    logic        a_start, a_ready, a_ren, a_valid, a_sof, a_sol, a_eol, a_busy;
    logic [19:0] a_base, a_addr;
    logic [23:0] a_q, a_data;
    int          a_reads = 0;

    // 4x1 instance
    logic        b_start, b_ready, b_ren, b_valid, b_sof, b_sol, b_eol, b_busy;
    logic [19:0] b_base, b_addr;
    logic [23:0] b_q, b_data;
    logic [19:0] b_addrs [8];
    int          b_nreads = 0;

    // 128x128 instance
    logic        c_start, c_ready, c_ren, c_valid, c_sof, c_sol, c_eol, c_busy;
    logic [19:0] c_base, c_addr;
    logic [23:0] c_q, c_data;

    always @(posedge clk) begin
        if (a_ren) begin
            a_q <= {4'h0, a_addr};
            a_reads++;
        end
    end

    always @(posedge clk) begin
        if (b_ren) begin
            b_q <= {4'h0, b_addr};
            if (b_nreads < 8) b_addrs[b_nreads] = b_addr;
            b_nreads++;
        end
    end

    always @(posedge clk) begin
        if (c_ren) c_q <= {4'h0, c_addr};
    end

    fb_scanout #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .fb_base(a_base),
        .FB_A(a_addr), .FB_REN(a_ren), .FB_Q(a_q),
        .pix_valid(a_valid), .pix_ready(a_ready), .pix_data(a_data),
        .pix_sof(a_sof), .pix_sol(a_sol), .pix_eol(a_eol), .busy(a_busy)
    );

    fb_scanout #(.WIDTH(4), .HEIGHT(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .fb_base(b_base),
        .FB_A(b_addr), .FB_REN(b_ren), .FB_Q(b_q),
        .pix_valid(b_valid), .pix_ready(b_ready), .pix_data(b_data),
        .pix_sof(b_sof), .pix_sol(b_sol), .pix_eol(b_eol), .busy(b_busy)
    );

    fb_scanout #(.WIDTH(128), .HEIGHT(128), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .fb_base(c_base),
        .FB_A(c_addr), .FB_REN(c_ren), .FB_Q(c_q),
        .pix_valid(c_valid), .pix_ready(c_ready), .pix_data(c_data),
        .pix_sof(c_sof), .pix_sol(c_sol), .pix_eol(c_eol), .busy(c_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called at a negedge; holds start for exactly one rising edge.
    task automatic applyStimulus(input int which, input logic [19:0] base);
        case (which)
            0: begin a_base = base; a_start = 1'b1; end
            1: begin b_base = base; b_start = 1'b1; end
            default: begin c_base = base; c_start = 1'b1; end
        endcase
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
    endtask

    function automatic logic validOf(input int which);
        case (which)
            0:       return a_valid;
            1:       return b_valid;
            default: return c_valid;
        endcase
    endfunction

    // cyc counts negedges since start was raised; first pixel expected at 3.
    task automatic waitValid(input int which, input string tag, output int cyc);
        cyc = 1;
        while (!validOf(which) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(tag, validOf(which), 1'b1);
    endtask

    task automatic checkPixA(input string tag, input int i, input logic [23:0] exp_data);
        checkOutput({tag, "_valid"}, a_valid, 1'b1);
        checkOutput({tag, "_data"}, a_data, exp_data);
        checkOutput({tag, "_sof"}, a_sof, i == 0);
        checkOutput({tag, "_sol"}, a_sol, (i % 4) == 0);
        checkOutput({tag, "_eol"}, a_eol, (i % 4) == 3);
        checkOutput({tag, "_busy"}, a_busy, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int r0;
        int idx;
        logic [19:0] exp_a [4];

        reset   = 1'b1;
        a_start = 1'b0; a_base = '0; a_ready = 1'b1;
        b_start = 1'b0; b_base = '0; b_ready = 1'b1;
        c_start = 1'b0; c_base = '0; c_ready = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_valid", a_valid, 1'b0);
        checkOutput("rst_data", a_data, 24'h0);
        checkOutput("rst_busy", a_busy, 1'b0);
        checkOutput("rst_ren", a_ren, 1'b0);
        checkOutput("rst_addr", a_addr, 20'h0);
        checkOutput("rst_sof", a_sof, 1'b0);
        checkOutput("rst_sol", a_sol, 1'b0);
        checkOutput("rst_eol", a_eol, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic 4x2 frame");
        applyStimulus(0, 20'h00100);
        waitValid(0, "t1_wait", cyc);
        checkOutput("t1_latency", cyc, 3);
        for (int i = 0; i < 8; i++) begin
            checkPixA("t1", i, 24'h000100 + 24'(i));
            @(negedge clk);
        end
        checkOutput("t1_busy_end", a_busy, 1'b0);
        checkOutput("t1_valid_end", a_valid, 1'b0);

        $display("[TB] back-pressure");
        a_ready = 1'b0;
        r0 = a_reads;
        applyStimulus(0, 20'h00100);
        waitValid(0, "t2_wait", cyc);
        for (int k = 0; k < 10; k++) begin
            checkOutput("t2_hold", a_data, 24'h000100);
            @(negedge clk);
        end
        checkOutput("t2_reads", a_reads - r0, 4);
        checkOutput("t2_ren_off", a_ren, 1'b0);
        checkOutput("t2_sof_hold", a_sof, 1'b1);
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkPixA("t2", i, 24'h000100 + 24'(i));
            @(negedge clk);
        end
        checkOutput("t2_busy_end", a_busy, 1'b0);
        checkOutput("t2_reads_total", a_reads - r0, 8);

        $display("[TB] address wrap");
        exp_a = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        applyStimulus(1, 20'hFFFFE);
        waitValid(1, "t3_wait", cyc);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_valid", b_valid, 1'b1);
            checkOutput("t3_data", b_data, {4'h0, exp_a[i]});
            checkOutput("t3_sof", b_sof, i == 0);
            checkOutput("t3_eol", b_eol, i == 3);
            @(negedge clk);
        end
        checkOutput("t3_busy_end", b_busy, 1'b0);
        checkOutput("t3_nreads", b_nreads, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_fb_a", b_addrs[i], exp_a[i]);
        end

        $display("[TB] start re-pulse mid-frame");
        applyStimulus(0, 20'h00100);
        waitValid(0, "t4_wait", cyc);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                a_start = 1'b1;
                a_base  = 20'h00300;
            end else begin
                a_start = 1'b0;
            end
            checkPixA("t4", i, 24'h000100 + 24'(i));
            @(negedge clk);
        end
        a_start = 1'b0;
        checkOutput("t4_busy_end", a_busy, 1'b0);
        @(negedge clk);
        checkOutput("t4_idle_busy", a_busy, 1'b0);
        checkOutput("t4_idle_ren", a_ren, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 20'h00100);
        waitValid(0, "t5_wait", cyc);
        repeat (5) @(negedge clk);
        checkOutput("t5_pre_data", a_data, 24'h000105);
        reset = 1'b1;
        #1;
        checkOutput("t5_valid", a_valid, 1'b0);
        checkOutput("t5_data", a_data, 24'h0);
        checkOutput("t5_sof", a_sof, 1'b0);
        checkOutput("t5_sol", a_sol, 1'b0);
        checkOutput("t5_eol", a_eol, 1'b0);
        checkOutput("t5_busy", a_busy, 1'b0);
        checkOutput("t5_ren", a_ren, 1'b0);
        checkOutput("t5_addr", a_addr, 20'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(0, 20'h00200);
        waitValid(0, "t5_wait2", cyc);
        checkOutput("t5_latency", cyc, 3);
        for (int i = 0; i < 8; i++) begin
            checkPixA("t5", i, 24'h000200 + 24'(i));
            @(negedge clk);
        end
        checkOutput("t5_busy_end", a_busy, 1'b0);

        $display("[TB] 128x128 frame, random ready");
        applyStimulus(2, 20'h01000);
        idx = 0;
        cyc = 0;
        while (idx < 16384 && cyc < 60000) begin
            c_ready = 1'($urandom_range(0, 1));
            if (c_valid && c_ready) begin
                checkOutput("t6_data", c_data, 24'h001000 + 24'(idx));
                checkOutput("t6_sof", c_sof, idx == 0);
                checkOutput("t6_sol", c_sol, (idx % 128) == 0);
                checkOutput("t6_eol", c_eol, (idx % 128) == 127);
                checkOutput("t6_busy", c_busy, 1'b1);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        c_ready = 1'b0;
        checkOutput("t6_count", idx, 16384);
        checkOutput("t6_busy_end", c_busy, 1'b0);
        checkOutput("t6_valid_end", c_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Downstream stage of the photo-album compositor: reads the finished frame buffer from image memory and emits it as a raster pixel stream with start-of-frame, start-of-line and end-of-line markers.
- Has its own read-only image-memory port (FB_A/FB_REN/FB_Q) with fixed 1-cycle read latency.
- Prefetches into a small FIFO so a valid/ready consumer can stall without losing data.

Parameters:
- WIDTH, 128, pixels per line.
- HEIGHT, 128, lines per frame.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: latch fb_base and scan one frame.
- fb_base  in  20  frame-buffer base word address in image memory.
- FB_A  out  20  image-memory read address.
- FB_REN  out  1  read enable; FB_Q is valid in the cycle after.
- FB_Q  in  24  read data {R,G,B}.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  consumer accepts when pix_valid && pix_ready.
- pix_data  out  24  pixel {R,G,B}.
- pix_sof  out  1  qualifies pixel (0,0).
- pix_sol  out  1  qualifies x==0.
- pix_eol  out  1  qualifies x==WIDTH-1.
- busy  out  1  high from the accepted start until the last pixel is accepted.

Behaviour:
- Reset values (asynchronous): FB_A=0, FB_REN=0, pix_valid=0, pix_data=0, pix_sof=0, pix_sol=0, pix_eol=0, busy=0. FIFO is emptied, all counters are 0, state is IDLE.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start=1 latches fb_base into rd_addr, clears rd_cnt and the output x/y counters, sets busy next cycle, and moves to FETCH.
  - FETCH: issues one read per cycle while credit is available. After the read with rd_cnt==WIDTH*HEIGHT-1 it moves to DRAIN.
  - DRAIN: no further reads. When the last pixel is accepted (out_x==WIDTH-1, out_y==HEIGHT-1), it moves to IDLE and busy=0 in the next cycle.
- start is ignored when the state is not IDLE.
- Read issue:
  - FB_REN=1 when state==FETCH and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is 1 in the cycle after FB_REN, otherwise 0.
  - FB_A = rd_addr, combinational from the register.
  - rd_addr increments by 1 per issued read, modulo 2^20; wrap-around past 0xFFFFF is legal and not flagged.
  - Linear addressing: pixel (x,y) is at fb_base + y*WIDTH + x.
- Capture: in the cycle after FB_REN, FB_Q is pushed into the FIFO unconditionally. The credit rule guarantees the FIFO is never pushed while full.
- Output:
  - pix_valid = FIFO not empty; pix_data = FIFO head (first-word-fall-through, 0-cycle show-ahead).
  - Markers are decoded combinationally from out_x/out_y.
  - On handshake, the FIFO pops and out_x increments; at WIDTH-1, out_x wraps to 0 and out_y increments.
  - With pix_valid=1 and pix_ready=0, pix_data and the markers hold stable.
- Simultaneous push and pop in one cycle: count is unchanged and both operations occur. Pop of the last entry and push in the same cycle is legal.
- Latency: with pix_ready held at 1, the first pixel is valid 3 cycles after start is sampled (latch, read, capture). After that the throughput is 1 pixel/cycle.
- Reset mid-frame: everything returns to reset values immediately. The next start begins a fresh frame from (0,0).
- start asserted in the same cycle the last pixel is accepted is ignored, because the state is still DRAIN.

Decomposition:
- Shared package holds:
  - the FB_AW=20 and PIX_W=24 constants;
  - the state encoding localparams S_IDLE=0, S_FETCH=1, S_DRAIN=2;
  - the default WIDTH/HEIGHT of 128.
- One sub-module: fb_fifo, a synchronous FIFO with first-word-fall-through. Parameters are data width and depth. Ports are push, pop, din, dout, empty, full, count. It uses the same asynchronous active-high reset.

Test Plan:
- WIDTH=4, HEIGHT=2, fb_base=0x00100, pix_ready=1, memory[a]=a → 8 pixels with data 0x000100..0x000107, one per cycle. sof on the first pixel; sol on 0x100 and 0x104; eol on 0x103 and 0x107; busy drops the cycle after the 8th accept.
- Same setup with pix_ready=0 for 10 cycles after the first valid → FB_REN stops after exactly FIFO_DEPTH reads and pix_data holds 0x000100. On release, the data is gap-free and in order.
- Random pix_ready (50%) over a 128x128 frame → 16384 pixels in address order; no FIFO overflow or underflow assertion fires.
- fb_base=0xFFFFE, WIDTH=4, HEIGHT=1 → FB_A sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- start re-pulsed mid-frame → ignored; the frame completes unchanged and busy stays high throughout.
- reset asserted after 5 accepts → all outputs are 0 asynchronously. A new start with fb_base=0x00200 yields a first pixel of 0x000200 with sof=1.
